// File: rtl/seg7_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Feeds packed BCD digits to the seven-segment driver; saturates to all nines on overflow.
module seg7_bcd_conv #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_W-1:0]       i_bin,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t             state_reg, state_next;
    logic [IN_W-1:0]    bin_sh_reg, bin_sh_next;
    logic [BCD_W-1:0]   bcd_sh_reg, bcd_sh_next;
    logic               ovf_r_reg, ovf_r_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BCD_W-1:0]   bcd_out_reg, bcd_out_next;
    logic               ovf_out_reg, ovf_out_next;
    logic               done_reg, done_next;
    logic [BCD_W-1:0]   bcd_adj;

    // Add-3 correction on every digit that would reach 10 or more after doubling.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_sh_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_sh_reg[gi*4 +: 4] + 4'd3
                                      : bcd_sh_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            bin_sh_reg  <= '0;
            bcd_sh_reg  <= '0;
            ovf_r_reg   <= 1'b0;
            cnt_reg     <= '0;
            bcd_out_reg <= '0;
            ovf_out_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bin_sh_reg  <= bin_sh_next;
            bcd_sh_reg  <= bcd_sh_next;
            ovf_r_reg   <= ovf_r_next;
            cnt_reg     <= cnt_next;
            bcd_out_reg <= bcd_out_next;
            ovf_out_reg <= ovf_out_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bin_sh_next  = bin_sh_reg;
        bcd_sh_next  = bcd_sh_reg;
        ovf_r_next   = ovf_r_reg;
        cnt_next     = cnt_reg;
        bcd_out_next = bcd_out_reg;
        ovf_out_next = ovf_out_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    bin_sh_next = i_bin;
                    bcd_sh_next = '0;
                    ovf_r_next  = 1'b0;
                    cnt_next    = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_sh_next, bin_sh_next} = {bcd_adj[BCD_W-2:0], bin_sh_reg, 1'b0};
                // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
                if (bcd_adj[BCD_W-1])
                    ovf_r_next = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST)
                    state_next = LOAD;
            end
            LOAD: begin
                if (ovf_r_reg) begin
                    bcd_out_next = {DIGITS{4'h9}};
                    ovf_out_next = 1'b1;
                end else begin
                    bcd_out_next = bcd_sh_reg;
                    ovf_out_next = 1'b0;
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_busy = (state_reg != IDLE);
    assign o_done = done_reg;
    assign o_bcd  = bcd_out_reg;
    assign o_ovf  = ovf_out_reg;
endmodule

// File: tb/tb_seg7_bcd_conv.sv
// Directed bench for seg7_bcd_conv: latency, exact conversions, saturation,
// start-while-busy, mid-conversion reset and continuous re-triggering.
module tb_seg7_bcd_conv;
    logic        clk;
    logic        reset;
    logic [31:0] i_bin;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_bcd;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;

    seg7_bcd_conv #(.IN_W(32), .DIGITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_bin   (i_bin),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bcd   (o_bcd),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns just after the accepting edge.
    task automatic start_conv(input logic [31:0] v);
        i_bin   = v;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Edges until o_done, and number of sampled cycles with o_busy high before it.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (!o_done && edges < 100) begin
            if (o_busy) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int e, b;
        start_conv(v);
        wait_done(e, b);
        check({tag, "_latency"}, e, 33);
        check({tag, "_bcd"}, o_bcd, exp_bcd);
        check({tag, "_ovf"}, {31'd0, o_ovf}, {31'd0, exp_ovf});
        $display("conv %s in=%h bcd=%h ovf=%0b edges=%0d", tag, v, o_bcd, o_ovf, e);
    endtask

    task automatic count_dones(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_done) dones++;
        end
    endtask

    initial begin
        int e, b, d, busy_bad, bcd_bad;
        reset   = 1'b1;
        i_bin   = '0;
        i_start = 1'b0;
        #1;
        check("rst_bcd",  o_bcd, 32'h0);
        check("rst_flags", {28'd0, o_busy, o_done, o_ovf, 1'b0}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        $display("reset released busy=%0b done=%0b", o_busy, o_done);

        // Zero: busy for 33 cycles, done one cycle later, one-cycle pulse.
        start_conv(32'd0);
        check("zero_busy_after_accept", {31'd0, o_busy}, 32'd1);
        wait_done(e, b);
        check("zero_busy_cycles", b, 33);
        check("zero_latency", e, 33);
        check("zero_busy_in_done", {31'd0, o_busy}, 32'd0);
        check("zero_bcd", o_bcd, 32'h0);
        check("zero_ovf", {31'd0, o_ovf}, 32'd0);
        tick();
        check("zero_done_one_cycle", {31'd0, o_done}, 32'd0);
        $display("conv zero bcd=%h busy_cycles=%0d", o_bcd, b);

        convert("12345678", 32'h00BC614E, 32'h12345678, 1'b0);
        convert("max_exact", 32'h05F5E0FF, 32'h99999999, 1'b0);
        convert("first_ovf", 32'h05F5E100, 32'h99999999, 1'b1);
        tick();
        check("ovf_hold", {31'd0, o_ovf}, 32'd1);
        convert("all_ones", 32'hFFFFFFFF, 32'h99999999, 1'b1);
        convert("small", 32'd255, 32'h00000255, 1'b0);

        // Start while busy is ignored, and i_bin changes do not disturb it.
        start_conv(32'd42);
        for (int i = 0; i < 4; i++) tick();
        i_bin   = 32'd7;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(e, b);
        check("busy_start_latency", e, 28);
        check("busy_start_bcd", o_bcd, 32'h00000042);
        count_dones(40, d);
        check("busy_start_no_extra_done", d, 0);
        check("busy_start_bcd_hold", o_bcd, 32'h00000042);
        $display("busy-start bcd=%h extra_dones=%0d", o_bcd, d);

        // Reset in the middle of a conversion aborts it.
        start_conv(32'd12345);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_bcd", o_bcd, 32'h0);
        tick();
        reset = 1'b0;
        count_dones(40, d);
        check("abort_no_done", d, 0);
        $display("abort busy=%0b bcd=%h dones=%0d", o_busy, o_bcd, d);
        convert("after_abort", 32'd12345, 32'h00012345, 1'b0);

        // Held start re-triggers every 34 cycles.
        i_bin   = 32'd9;
        i_start = 1'b1;
        tick();
        wait_done(e, b);
        check("held_first_latency", e, 33);
        check("held_first_bcd", o_bcd, 32'h00000009);
        for (int k = 0; k < 2; k++) begin
            busy_bad = 0;
            bcd_bad  = 0;
            e        = 0;
            do begin
                tick();
                e++;
                if (o_bcd !== 32'h00000009) bcd_bad++;
                if (!o_done && !o_busy) busy_bad++;
            end while (!o_done && e < 100);
            check("held_period", e, 34);
            check("held_busy_low_only_done", busy_bad, 0);
            check("held_busy_in_done", {31'd0, o_busy}, 32'd0);
            check("held_bcd_const", bcd_bad, 0);
            $display("held period %0d edges=%0d bcd=%h", k, e, o_bcd);
        end
        i_start = 1'b0;
        tick();
        check("held_release_idle", {31'd0, o_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
